sys_arr_ctrl: RTL and testbench
===============================

# sys_arr_ctrl

Sequencing controller for the N×N weight-stationary systolic array (`SysArray`). It accepts N weight rows and then a counted stream of activation vectors over valid/ready handshakes. It drives the array's weight-load and activation ports, applying the per-lane diagonal input skew, then de-skews the column outputs into aligned result words. It sits between the buffer/DMA side and the array, and is the only block that drives `SysArray` inputs.

## Interface
- `N`, 4, array width/height (rows = columns).
- `DW`, 4, bits per data and weight element.
- `SW`, 8, bits per column partial sum.
- `ARR_LAT`, 4, cycles from lane-0 issue on `arr_data_in` to column-0 `arr_mac_out` valid. Column j is valid `ARR_LAT+j` cycles after issue.
- `clk  in  1`  clock, all logic on rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `start  in  1`  job start pulse; sampled only in IDLE.
- `num_vecs  in  8`  activation vectors in the job; latched on accepted `start`.
- `keep_w  in  1`  reuse loaded weights; latched on `start`. Ignored unless `SYS_ARR_CTRL_REUSE_EN` is defined.
- `busy  out  1`  high whenever state ≠ IDLE.
- `done  out  1`  one-cycle pulse at job end.
- `w_valid`/`w_ready`  in/out  1  weight-row handshake.
- `w_row  in  N*DW`  weight row.
- `act_valid`/`act_ready`  in/out  1  activation-vector handshake.
- `act_vec  in  N*DW`  activation vector; lane i = `[i*DW +: DW]`.
- `arr_weight_wren  out  N`  to array.
- `arr_w_in  out  N*DW`  to array.
- `arr_active  out  1`  to array.
- `arr_data_in  out  N*DW`  to array (skewed).
- `arr_sum_in  out  N*SW`  to array; constant 0.
- `arr_mac_out  in  N*SW`  from array; column j = `[j*SW +: SW]`.
- `res_valid  out  1`  aligned result valid.
- `res_data  out  N*SW`  aligned result, column j in `[j*SW +: SW]`.

## Operation
- States are IDLE, LOAD_W, STREAM, DRAIN and DONE.
- **IDLE:** on `start`, latch `num_vecs` and `keep_w`.
  - If reuse applies (see Configuration), go to STREAM.
  - Otherwise go to LOAD_W.
- **LOAD_W:** `w_ready=1`. Each accepted row is registered onto `arr_w_in` with `arr_weight_wren` all-ones for exactly one cycle, so rows shift into the array in acceptance order.
  - Cycles without a beat drive `arr_weight_wren=0`.
  - After the Nth beat, set `w_loaded` and go to STREAM. If the latched `num_vecs==0`, go to DONE instead.
- **STREAM:** `act_ready=1` while the remaining count is greater than 0.
  - An accepted vector enters lane-0 issue with a valid token. A non-accepting cycle issues a zero bubble with no token.
  - Lane i of the vector passes through i extra register stages, so lane i reaches `arr_data_in` i cycles after lane 0.
  - `arr_active` is the lane-0 token.
  - When the count reaches 0, go to DRAIN.
- **Token tracking:** each token travels a delay line of length `ARR_LAT+N-1`.
- **Output de-skew:** column j is registered through `N-1-j` stages.
  - `res_valid` is the delayed token.
  - `res_data` is the aligned columns.
- **Outstanding counter:** increments on issue and decrements on `res_valid`.
- **DRAIN:** go to DONE when the outstanding count is 0.
- **DONE:** `done=1` for one cycle, then go to IDLE.
- **Boundary rules:**
  - `start` while busy is ignored.
  - `w_valid`/`act_valid` are ignored outside their states.
  - Unused skew lanes drive 0.
  - No backpressure on results.
  - Column sums are not modified. Array wrap-around (mod 2^SW) passes through.
- **`rst`** at any cycle:
  - state returns to IDLE;
  - all skew, token and de-skew registers, counters and `w_loaded` clear;
  - every output is 0 on the following cycle, and `arr_sum_in` is always 0.

## Timing
- Weight beat accepted at edge t: `arr_w_in` and `arr_weight_wren` are valid in cycle t+1.
- Nth weight beat at t: `act_ready` first high in cycle t+1.
- Vector accepted at edge t:
  - lane 0 on `arr_data_in` and `arr_active=1` in cycle t+1;
  - lane i in cycle t+1+i;
  - `res_valid` in cycle t+`ARR_LAT`+N. With defaults this is t+8.
- Back-to-back vectors give back-to-back `res_valid`; throughput is 1 vector/cycle.
- `done` asserts one cycle after the last `res_valid`. `busy` falls in the cycle after `done`.

## Configuration
- `SYS_ARR_CTRL_REUSE_EN` defined:
  - `start` with `keep_w=1` and `w_loaded=1` skips LOAD_W and enters STREAM directly.
  - With `keep_w=1` and `num_vecs==0`, go straight to DONE.
  - `keep_w=1` with `w_loaded=0` loads normally.
- Undefined: `keep_w` is ignored, every job runs LOAD_W, and the `w_loaded` logic is not built.

## Test plan
- **Uniform weights:** all weights 1 (4 beats), then one vector {4,3,2,1}.
  - Lane 0 appears on `arr_data_in` 1 cycle after the handshake, lane 3 after 4 cycles.
  - `res_data` = four columns of 10, `res_valid` 8 cycles after acceptance, `done` one cycle later.
- **Stall tolerance:** weights all 2; 3 vectors of all-15 with `act_valid` dropping 2 cycles between vectors.
  - Three results of 120 per column, spaced by the same gaps; bubbles produce no `res_valid`.
- **Overflow pass-through:** weights all 15, vector all 15 → each column 132 (900 mod 256).
- **Zero vectors:** `num_vecs=0` → LOAD_W then `done` one cycle after the 4th weight beat; `act_ready` never asserts.
- **Reset mid-operation:** `rst` pulsed during STREAM with 2 tokens in flight.
  - Next cycle: `busy`, `arr_active`, `arr_data_in`, `arr_weight_wren`, `res_valid` and `done` are all 0.
  - No stale `res_valid` appears afterwards.
- **Weight reuse** (macro defined): second job with `keep_w=1` receives no weight beats and accepts its first vector 2 cycles after `start`. Repeat with the macro undefined: `w_ready` asserts instead.

Source files
------------

// File: rtl/sys_arr_ctrl.sv
// sys_arr_ctrl: sequencing controller for the NxN weight-stationary systolic array.
// Loads N weight rows, streams a counted run of activation vectors with the
// per-lane diagonal skew, then de-skews the column sums into aligned result words.
// Optional weight reuse across jobs is built only when SYS_ARR_CTRL_REUSE_EN is defined.
module sys_arr_ctrl #(
  parameter int N       = 4,
  parameter int DW      = 4,
  parameter int SW      = 8,
  parameter int ARR_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      num_vecs,
  input  logic            keep_w,
  output logic            busy,
  output logic            done,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [N*DW-1:0] w_row,
  input  logic            act_valid,
  output logic            act_ready,
  input  logic [N*DW-1:0] act_vec,
  output logic [N-1:0]    arr_weight_wren,
  output logic [N*DW-1:0] arr_w_in,
  output logic            arr_active,
  output logic [N*DW-1:0] arr_data_in,
  output logic [N*SW-1:0] arr_sum_in,
  input  logic [N*SW-1:0] arr_mac_out,
  output logic            res_valid,
  output logic [N*SW-1:0] res_data
);

  // Token stages after the lane-0 issue register until the last column is valid.
  localparam int TOK_LEN = ARR_LAT + N - 1;
  localparam int WCW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        rem_r;
  logic [7:0]        out_cnt_r;
  logic [WCW-1:0]    wcnt_r;
  logic [TOK_LEN:0]  tok_r;
  logic [N-1:0]      wren_r;
  logic [N*DW-1:0]   w_in_r;
  logic              w_fire_s;
  logic              act_fire_s;

`ifdef SYS_ARR_CTRL_REUSE_EN
  logic              w_loaded_r;
`else
  logic              unused_keep_w_s;
  assign unused_keep_w_s = keep_w;
`endif

  assign w_fire_s   = (state_r == S_LOAD_W) && w_valid;
  assign act_fire_s = act_ready && act_valid;

  assign arr_sum_in      = '0;
  assign arr_weight_wren = wren_r;
  assign arr_w_in        = w_in_r;
  assign arr_active      = tok_r[0];
  assign res_valid       = tok_r[TOK_LEN];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
`ifdef SYS_ARR_CTRL_REUSE_EN
          if (keep_w && w_loaded_r) begin
            if (num_vecs == 8'd0) begin
              state_s = S_DONE;
            end else begin
              state_s = S_STREAM;
            end
          end else begin
            state_s = S_LOAD_W;
          end
`else
          state_s = S_LOAD_W;
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD_W: begin
        if (w_fire_s && (wcnt_r == W_LAST)) begin
          if (rem_r == 8'd0) begin
            state_s = S_DONE;
          end else begin
            state_s = S_STREAM;
          end
        end else begin
          state_s = S_LOAD_W;
        end
      end
      S_STREAM: begin
        if ((rem_r == 8'd0) || (act_fire_s && (rem_r == 8'd1))) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_STREAM;
        end
      end
      S_DRAIN: begin
        // Leave as the last result retires so done lands right after it.
        if ((out_cnt_r == 8'd0) || ((out_cnt_r == 8'd1) && res_valid)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    busy      = (state_r != S_IDLE);
    done      = (state_r == S_DONE);
    w_ready   = (state_r == S_LOAD_W);
    act_ready = (state_r == S_STREAM) && (rem_r != 8'd0);
  end

  // Job counters: remaining vectors and accepted weight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r  <= 8'd0;
      wcnt_r <= '0;
    end else begin
      if ((state_r == S_IDLE) && start) begin
        rem_r  <= num_vecs;
        wcnt_r <= '0;
      end else begin
        if (act_fire_s) begin
          rem_r <= rem_r - 8'd1;
        end else begin
          rem_r <= rem_r;
        end
        if (w_fire_s) begin
          wcnt_r <= wcnt_r + {{(WCW-1){1'b0}}, 1'b1};
        end else begin
          wcnt_r <= wcnt_r;
        end
      end
    end
  end

`ifdef SYS_ARR_CTRL_REUSE_EN
  // Remember that a full weight set sits in the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_loaded_r <= 1'b0;
    end else if (w_fire_s && (wcnt_r == W_LAST)) begin
      w_loaded_r <= 1'b1;
    end else begin
      w_loaded_r <= w_loaded_r;
    end
  end
`endif

  // Weight row register: one-cycle write strobe per accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wren_r <= '0;
      w_in_r <= '0;
    end else if (w_fire_s) begin
      wren_r <= {N{1'b1}};
      w_in_r <= w_row;
    end else begin
      wren_r <= '0;
      w_in_r <= w_in_r;
    end
  end

  // Token delay line: bit 0 drives arr_active, the last bit is res_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_r <= '0;
    end else begin
      tok_r <= {tok_r[TOK_LEN-1:0], act_fire_s};
    end
  end

  // Outstanding vectors: issued but not yet presented as a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt_r <= 8'd0;
    end else begin
      case ({act_fire_s, res_valid})
        2'b10:   out_cnt_r <= out_cnt_r + 8'd1;
        2'b01:   out_cnt_r <= out_cnt_r - 8'd1;
        default: out_cnt_r <= out_cnt_r;
      endcase
    end
  end

  // Input skew: lane i sits behind i extra stages; bubbles issue zeros.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DW-1:0] pipe_r [0:gi];

    // Lane gi skew pipeline.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= gi; k++) begin
          pipe_r[k] <= '0;
        end
      end else begin
        pipe_r[0] <= act_fire_s ? act_vec[gi*DW +: DW] : '0;
        for (int k = 1; k <= gi; k++) begin
          pipe_r[k] <= pipe_r[k-1];
        end
      end
    end

    assign arr_data_in[gi*DW +: DW] = pipe_r[gi];
  end

  // Output de-skew: column j waits N-1-j stages so all columns align.
  for (genvar gj = 0; gj < N; gj++) begin : g_deskew
    localparam int DEPTH = N - 1 - gj;
    logic [SW-1:0] col_s;

    if (DEPTH == 0) begin : g_pass
      assign col_s = arr_mac_out[gj*SW +: SW];
    end else begin : g_pipe
      logic [SW-1:0] dpipe_r [0:DEPTH-1];

      // Column gj de-skew pipeline.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) begin
            dpipe_r[k] <= '0;
          end
        end else begin
          dpipe_r[0] <= arr_mac_out[gj*SW +: SW];
          for (int k = 1; k < DEPTH; k++) begin
            dpipe_r[k] <= dpipe_r[k-1];
          end
        end
      end

      assign col_s = dpipe_r[DEPTH-1];
    end

    // Result word is held at zero whenever no aligned result is presented.
    assign res_data[gj*SW +: SW] = res_valid ? col_s : '0;
  end

endmodule

// File: tb/tb_sys_arr_ctrl.sv
// Scoreboard bench for sys_arr_ctrl with a behavioural weight-stationary array model.
module tb_sys_arr_ctrl;
  localparam int N = 4, DW = 4, SW = 8, ARR_LAT = 4;
  localparam int H = 4096;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      num_vecs = 8'd0;
  logic            keep_w = 1'b0;
  logic            busy, done, w_ready, act_ready, arr_active, res_valid;
  logic            w_valid = 1'b0;
  logic            act_valid = 1'b0;
  logic [15:0]     w_row = 16'h0;
  logic [15:0]     act_vec = 16'h0;
  logic [3:0]      arr_weight_wren;
  logic [15:0]     arr_w_in, arr_data_in;
  logic [31:0]     arr_sum_in, res_data;
  logic [31:0]     arr_mac_out = 32'h0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t exp_q[$];
  int   done_q[$];

  bit [15:0] hist_d [0:H-1];
  bit        hist_a [0:H-1];
  logic [15:0] wmat [0:N-1];

  sys_arr_ctrl #(.N(N), .DW(DW), .SW(SW), .ARR_LAT(ARR_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs), .keep_w(keep_w),
    .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .act_valid(act_valid), .act_ready(act_ready), .act_vec(act_vec),
    .arr_weight_wren(arr_weight_wren), .arr_w_in(arr_w_in), .arr_active(arr_active),
    .arr_data_in(arr_data_in), .arr_sum_in(arr_sum_in), .arr_mac_out(arr_mac_out),
    .res_valid(res_valid), .res_data(res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rep(input logic [7:0] c);
    return {c, c, c, c};
  endfunction

  // Array model: weight rows shift in on wren; column j of a vector issued in
  // cycle t0 appears in cycle t0+ARR_LAT+j; idle columns carry a junk pattern.
  always @(posedge clk) begin
    logic [31:0] mac;
    logic [7:0]  s;
    int          t0;
    #1;
    hist_d[cyc % H] = arr_data_in;
    hist_a[cyc % H] = arr_active;
    if (arr_weight_wren != 4'h0) begin
      for (int r = N - 1; r > 0; r--) wmat[r] = wmat[r-1];
      wmat[0] = arr_w_in;
    end
    for (int j = 0; j < N; j++) begin
      t0 = cyc - ARR_LAT - j;
      s  = 8'hA5;
      if (t0 >= 0 && hist_a[t0 % H]) begin
        s = 8'h00;
        for (int i = 0; i < N; i++)
          s = s + 8'(hist_d[(t0 + i) % H][i*DW +: DW]) * 8'(wmat[i][j*DW +: DW]);
      end
      mac[j*SW +: SW] = s;
    end
    arr_mac_out = mac;
  end

  // Monitor: pops expectations whenever the DUT presents a result or done.
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (!rst && res_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (!rst && done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        d = done_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(d));
      end
    end
  end

  task automatic start_job(input logic [7:0] n, input logic kw);
    start = 1'b1; num_vecs = n; keep_w = kw;
    @(negedge clk);
    start = 1'b0; keep_w = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic send_w(input logic [15:0] row, input bit last_zero);
    int n = 0;
    w_valid = 1'b1; w_row = row;
    while (!w_ready && n < 50) begin @(negedge clk); n++; end
    if (!w_ready) begin
      chk("w_ready_timeout", 32'd0, 32'd1);
      w_valid = 1'b0;
    end else begin
      if (last_zero) done_q.push_back(cyc + 1);
      @(negedge clk);
      w_valid = 1'b0;
      chk("arr_weight_wren", {28'd0, arr_weight_wren}, 32'hF);
      chk("arr_w_in", {16'd0, arr_w_in}, {16'd0, row});
    end
  endtask

  task automatic send_vec(input logic [15:0] v, input logic [7:0] col, input bit exp_res,
                          input bit last, input int gap, output int acc);
    int n = 0;
    act_valid = 1'b1; act_vec = v; acc = -1;
    while (!act_ready && n < 50) begin @(negedge clk); n++; end
    if (!act_ready) begin
      chk("act_ready_timeout", 32'd0, 32'd1);
      act_valid = 1'b0;
    end else begin
      acc = cyc;
      if (exp_res) begin
        exp_q.push_back('{data: rep(col), cyc: cyc + ARR_LAT + N});
        if (last) done_q.push_back(cyc + ARR_LAT + N + 1);
      end
      @(negedge clk);
      act_valid = 1'b0; act_vec = 16'h0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic load4(input logic [15:0] row, input bit zero_job);
    for (int k = 0; k < 4; k++) send_w(row, zero_job && (k == 3));
  endtask

  initial begin
    int a;
    for (int r = 0; r < N; r++) wmat[r] = 16'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_w_ready", {31'd0, w_ready}, 32'd0);
    chk("rst_act_ready", {31'd0, act_ready}, 32'd0);
    chk("rst_sum_in", arr_sum_in, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Uniform weights, one vector {4,3,2,1} -> 10 per column
    start_job(8'd1, 1'b0);
    load4(16'h1111, 1'b0);
    chk("act_ready_after_load", {31'd0, act_ready}, 32'd1);
    w_valid = 1'b1; w_row = 16'hFFFF;
    @(negedge clk);
    chk("w_valid_ignored", {28'd0, arr_weight_wren}, 32'd0);
    w_valid = 1'b0;
    send_vec(16'h1234, 8'd10, 1'b1, 1'b1, 0, a);
    chk("lane0_data", {28'd0, arr_data_in[3:0]}, 32'd4);
    chk("lane0_active", {31'd0, arr_active}, 32'd1);
    repeat (3) @(negedge clk);
    chk("lane3_data", {28'd0, arr_data_in[15:12]}, 32'd1);
    chk("lanes_idle_zero", {20'd0, arr_data_in[11:0]}, 32'd0);
    wait_done();

    // Stall tolerance: weights 2, three all-15 vectors with 2-cycle gaps -> 120
    start_job(8'd3, 1'b0);
    load4(16'h2222, 1'b0);
    send_vec(16'hFFFF, 8'd120, 1'b1, 1'b0, 2, a);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_vec(16'hFFFF, 8'd120, 1'b1, 1'b0, 2, a);
    send_vec(16'hFFFF, 8'd120, 1'b1, 1'b1, 0, a);
    wait_done();

    // Overflow pass-through: 900 mod 256 = 132
    start_job(8'd1, 1'b0);
    load4(16'hFFFF, 1'b0);
    send_vec(16'hFFFF, 8'd132, 1'b1, 1'b1, 0, a);
    wait_done();

    // Zero vectors: done one cycle after the 4th weight beat
    start_job(8'd0, 1'b0);
    load4(16'h1111, 1'b1);
    chk("zero_act_ready", {31'd0, act_ready}, 32'd0);
    wait_done();

    // Reset during STREAM with two tokens in flight
    start_job(8'd4, 1'b0);
    load4(16'h1111, 1'b0);
    send_vec(16'h1111, 8'd0, 1'b0, 1'b0, 0, a);
    send_vec(16'h2222, 8'd0, 1'b0, 1'b0, 0, a);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_active", {31'd0, arr_active}, 32'd0);
    chk("mid_rst_data", {16'd0, arr_data_in}, 32'd0);
    chk("mid_rst_wren", {28'd0, arr_weight_wren}, 32'd0);
    chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // Weight reuse: weights 3, vector of ones -> 12; second job vector of twos -> 24
    start_job(8'd1, 1'b0);
    load4(16'h3333, 1'b0);
    send_vec(16'h1111, 8'd12, 1'b1, 1'b1, 0, a);
    wait_done();
    start_job(8'd1, 1'b1);
`ifdef SYS_ARR_CTRL_REUSE_EN
    chk("reuse_act_ready", {31'd0, act_ready}, 32'd1);
    chk("reuse_w_ready", {31'd0, w_ready}, 32'd0);
`else
    chk("noreuse_w_ready", {31'd0, w_ready}, 32'd1);
    load4(16'h3333, 1'b0);
`endif
    send_vec(16'h2222, 8'd24, 1'b1, 1'b1, 0, a);
    wait_done();

    repeat (5) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
